// File: rtl/mips_alu_issue.sv
// -----------------------------------------------------------------------------
// mips_alu_issue
//
// Decode/issue stage that sits directly in front of the MIPS ALU. It accepts
// one instruction per cycle together with its register-file operands and
// decodes opcode/funct into the ALU operation select. It registers the ALU
// operands, forwards the ALU result to a dependent instruction, and stalls
// for one cycle on a back-to-back dependency. It also carries a writeback tag
// that lines up with the ALU's registered output.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       instr/rs_data/rt_data carry an instruction
//   in_ready       instruction taken when in_valid & in_ready (combinational)
//   instr          MIPS instruction word
//   rs_data        register-file value of instr[25:21]
//   rt_data        register-file value of instr[20:16]
//   alu_result     ALU registered output, fed back for forwarding
//   a, b, csig     registered ALU operands and operation select
//   ex_valid       a/b/csig hold a real instruction
//   ex_dest        destination register of the EX instruction
//   wb_valid       alu_result is a result to write this cycle
//   wb_dest        write register for alu_result
//   wb_illegal     the WB-slot instruction was undecodable
//   stall_cnt      saturating count of interlock bubbles since reset
// -----------------------------------------------------------------------------
module mips_alu_issue #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instr,
    input  logic [31:0]            rs_data,
    input  logic [31:0]            rt_data,
    input  logic [31:0]            alu_result,
    output logic [31:0]            a,
    output logic [31:0]            b,
    output logic [3:0]             csig,
    output logic                   ex_valid,
    output logic [4:0]             ex_dest,
    output logic                   wb_valid,
    output logic [4:0]             wb_dest,
    output logic                   wb_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [3:0] {
        CS_OR   = 4'b0000,
        CS_AND  = 4'b0001,
        CS_XOR  = 4'b0010,
        CS_SLL  = 4'b0011,
        CS_SRL  = 4'b0100,
        CS_SUB  = 4'b0101,
        CS_ADD  = 4'b0110,
        CS_NOR  = 4'b0111,
        CS_SLT  = 4'b1001,
        CS_MUL  = 4'b1010,
        CS_ZERO = 4'b1011
    } csig_e;

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [4:0]  shamt;
    logic [15:0] imm;

    assign opcode = instr[31:26];
    assign rs_idx = instr[25:21];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    // Registered state
    logic [31:0]            a_q, a_d;
    logic [31:0]            b_q, b_d;
    csig_e                  csig_q, csig_d;
    logic                   ex_valid_q, ex_valid_d;
    logic [4:0]             ex_dest_q, ex_dest_d;
    logic                   ex_illegal_q, ex_illegal_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [4:0]             wb_dest_q, wb_dest_d;
    logic                   wb_illegal_q, wb_illegal_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Operand values after forwarding. The WB slot holds the producer one
    // instruction further back; register 0 is never forwarded.
    logic        fwd_rs;
    logic        fwd_rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign fwd_rs = wb_valid_q && (wb_dest_q != 5'd0) && (wb_dest_q == rs_idx);
    assign fwd_rt = wb_valid_q && (wb_dest_q != 5'd0) && (wb_dest_q == rt_idx);
    assign rs_val = fwd_rs ? alu_result : rs_data;
    assign rt_val = fwd_rt ? alu_result : rt_data;

    // Decode results
    csig_e       dec_csig;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_dest;
    logic        dec_illegal;
    logic        uses_rs;
    logic        uses_rt;
    logic        rrr_op;     // three-register form: a = rs, b = rt, dest = rd

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        dec_csig    = CS_ZERO;
        dec_a       = 32'd0;
        dec_b       = 32'd0;
        dec_dest    = 5'd0;
        dec_illegal = 1'b1;
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        rrr_op      = 1'b0;

        unique case (opcode)
            6'h00: begin
                unique case (funct)
                    6'h20, 6'h21: begin dec_csig = CS_ADD; rrr_op = 1'b1; end
                    6'h22, 6'h23: begin dec_csig = CS_SUB; rrr_op = 1'b1; end
                    6'h24:        begin dec_csig = CS_AND; rrr_op = 1'b1; end
                    6'h25:        begin dec_csig = CS_OR;  rrr_op = 1'b1; end
                    6'h26:        begin dec_csig = CS_XOR; rrr_op = 1'b1; end
                    6'h27:        begin dec_csig = CS_NOR; rrr_op = 1'b1; end
                    6'h2A:        begin dec_csig = CS_SLT; rrr_op = 1'b1; end
                    6'h00, 6'h02: begin
                        // Shift by constant: rs field is not read.
                        dec_csig    = (funct == 6'h00) ? CS_SLL : CS_SRL;
                        dec_a       = rt_val;
                        dec_b       = {27'd0, shamt};
                        dec_dest    = rd_idx;
                        dec_illegal = 1'b0;
                        uses_rt     = 1'b1;
                    end
                    6'h04, 6'h06: begin
                        // Variable shift: amount comes from rs.
                        dec_csig    = (funct == 6'h04) ? CS_SLL : CS_SRL;
                        dec_a       = rt_val;
                        dec_b       = rs_val;
                        dec_dest    = rd_idx;
                        dec_illegal = 1'b0;
                        uses_rs     = 1'b1;
                        uses_rt     = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'h1C: begin
                if (funct == 6'h02) begin
                    dec_csig = CS_MUL;
                    rrr_op   = 1'b1;
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                dec_a       = rs_val;
                dec_dest    = rt_idx;
                dec_illegal = 1'b0;
                uses_rs     = 1'b1;
                unique case (opcode)
                    6'h08, 6'h09: begin dec_csig = CS_ADD; dec_b = {{16{imm[15]}}, imm}; end
                    6'h0A:        begin dec_csig = CS_SLT; dec_b = {{16{imm[15]}}, imm}; end
                    6'h0C:        begin dec_csig = CS_AND; dec_b = {16'd0, imm}; end
                    6'h0D:        begin dec_csig = CS_OR;  dec_b = {16'd0, imm}; end
                    default:      begin dec_csig = CS_XOR; dec_b = {16'd0, imm}; end
                endcase
            end
            6'h0F: begin
                // LUI is an OR of the shifted immediate with zero.
                dec_csig    = CS_OR;
                dec_b       = {imm, 16'd0};
                dec_dest    = rt_idx;
                dec_illegal = 1'b0;
            end
            default: ;
        endcase

        if (rrr_op) begin
            dec_a       = rs_val;
            dec_b       = rt_val;
            dec_dest    = rd_idx;
            dec_illegal = 1'b0;
            uses_rs     = 1'b1;
            uses_rt     = 1'b1;
        end
    end

    // A source written by the EX instruction is not yet in alu_result, so
    // the consumer waits one cycle and then picks it up from the WB slot.
    logic hazard;

    assign hazard = in_valid && ex_valid_q && (ex_dest_q != 5'd0) &&
                    ((uses_rs && (rs_idx == ex_dest_q)) ||
                     (uses_rt && (rt_idx == ex_dest_q)));

    assign in_ready = !hazard;

    always_comb begin
        // Bubble unless an instruction is taken this cycle.
        a_d          = 32'd0;
        b_d          = 32'd0;
        csig_d       = CS_ZERO;
        ex_valid_d   = 1'b0;
        ex_dest_d    = 5'd0;
        ex_illegal_d = 1'b0;
        stall_cnt_d  = stall_cnt_q;

        if (in_valid && !hazard) begin
            a_d          = dec_a;
            b_d          = dec_b;
            csig_d       = dec_csig;
            ex_valid_d   = 1'b1;
            ex_dest_d    = dec_dest;
            ex_illegal_d = dec_illegal;
        end

        if (hazard && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        // The ALU registers its result on the same edge that moves EX to WB.
        wb_valid_d   = ex_valid_q && !ex_illegal_q;
        wb_dest_d    = ex_dest_q;
        wb_illegal_d = ex_valid_q && ex_illegal_q;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            csig_q       <= CS_ZERO;
            ex_valid_q   <= 1'b0;
            ex_dest_q    <= 5'd0;
            ex_illegal_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_dest_q    <= 5'd0;
            wb_illegal_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            csig_q       <= csig_d;
            ex_valid_q   <= ex_valid_d;
            ex_dest_q    <= ex_dest_d;
            ex_illegal_q <= ex_illegal_d;
            wb_valid_q   <= wb_valid_d;
            wb_dest_q    <= wb_dest_d;
            wb_illegal_q <= wb_illegal_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign csig       = csig_q;
    assign ex_valid   = ex_valid_q;
    assign ex_dest    = ex_dest_q;
    assign wb_valid   = wb_valid_q;
    assign wb_dest    = wb_dest_q;
    assign wb_illegal = wb_illegal_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
